// File: rtl/mult_sequencer_if.sv
// mult_sequencer_if
//   Bundles the pipeline-side start/operand/result signals and the shared ALU
//   hookup of the Booth multiply sequencer. clock and reset are not part of it.
//   Ports (from the sequencer's point of view, modport slave):
//     ctrl_MULT      in   start pulse, operands sampled on the same edge when idle
//     data_operandA  in   32-bit multiplicand, two's complement
//     data_operandB  in   32-bit multiplier, two's complement
//     alu_result     in   combinational result of the shared ALU
//     alu_overflow   in   signed-overflow flag of the shared ALU
//     alu_req        out  sequencer owns the ALU operand mux this cycle
//     alu_opA/opB    out  ALU operands (accumulator A / multiplicand M)
//     alu_opcode     out  5'b00000 add, 5'b00001 subtract
//     alu_shamt      out  always zero
//     busy           out  multiply in progress (RUN or DONE)
//     data_result    out  low 32 bits of the last product
//     data_exception out  last product did not fit in 32 bits
//     data_resultRDY out  one-cycle pulse when the result is valid
//   The master modport is the pipeline/ALU side that drives the inputs.
interface mult_sequencer_if;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] alu_result;
  logic        alu_overflow;
  logic        alu_req;
  logic [31:0] alu_opA;
  logic [31:0] alu_opB;
  logic [4:0]  alu_opcode;
  logic [4:0]  alu_shamt;
  logic        busy;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  modport master (
    output ctrl_MULT, data_operandA, data_operandB, alu_result, alu_overflow,
    input  alu_req, alu_opA, alu_opB, alu_opcode, alu_shamt,
           busy, data_result, data_exception, data_resultRDY
  );

  modport slave (
    input  ctrl_MULT, data_operandA, data_operandB, alu_result, alu_overflow,
    output alu_req, alu_opA, alu_opB, alu_opcode, alu_shamt,
           busy, data_result, data_exception, data_resultRDY
  );
endinterface

// File: rtl/mult_sequencer.sv
// mult_sequencer
//   Signed 32x32 radix-2 Booth multiplier controller. It owns no adder: each of
//   the 32 iterations borrows the processor's shared combinational ALU for one
//   add or subtract, then does the 65-bit arithmetic right shift locally.
//   Ports:
//     clock  in  rising-edge clock
//     reset  in  synchronous, active-high; dominates every other input
//     bus    mult_sequencer_if.slave - start/operands, shared ALU, result signals
module mult_sequencer (
  input logic             clock,
  input logic             reset,
  mult_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] m_q, m_d;
  logic [31:0] a_q, a_d;
  logic [31:0] q_q, q_d;
  logic        qm1_q, qm1_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;

  logic        useAlu;
  logic        doSub;
  logic [31:0] sum;
  logic        sign;
  logic [31:0] aShift;
  logic [31:0] qShift;

  // Booth step for the current iteration. When the ALU was used, the true sign
  // of the 33-bit sum is the result sign flipped by overflow; without this the
  // shift would bring in the wrong bit for M = 0x80000000.
  always_comb begin
    doSub  = q_q[0] & ~qm1_q;
    useAlu = q_q[0] ^ qm1_q;
    sum    = a_q;
    sign   = a_q[31];
    if (useAlu) begin
      sum  = bus.alu_result;
      sign = bus.alu_result[31] ^ bus.alu_overflow;
    end
    aShift = {sign, sum[31:1]};
    qShift = {sum[0], q_q[31:1]};
  end

  // Next-state logic: IDLE latches operands on a start pulse, RUN performs one
  // iteration per cycle and publishes the product on the last one, DONE lasts
  // a single cycle so the ready pulse is exactly one cycle wide.
  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    a_d      = a_q;
    q_d      = q_q;
    qm1_d    = qm1_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    exc_d    = exc_q;
    case (state_q)
      IDLE: begin
        if (bus.ctrl_MULT) begin
          m_d     = bus.data_operandA;
          q_d     = bus.data_operandB;
          a_d     = 32'd0;
          qm1_d   = 1'b0;
          cnt_d   = 6'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = aShift;
        q_d   = qShift;
        qm1_d = q_q[0];
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d  = DONE;
          result_d = qShift;
          // Product fits in 32 bits only if the upper half is pure sign extension.
          exc_d    = (aShift != {32{qShift[31]}});
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      m_q      <= 32'd0;
      a_q      <= 32'd0;
      q_q      <= 32'd0;
      qm1_q    <= 1'b0;
      cnt_q    <= 6'd0;
      result_q <= 32'd0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      a_q      <= a_d;
      q_q      <= q_d;
      qm1_q    <= qm1_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

  assign bus.alu_req        = (state_q == RUN);
  assign bus.alu_opA        = a_q;
  assign bus.alu_opB        = m_q;
  assign bus.alu_opcode     = {4'b0000, doSub};
  assign bus.alu_shamt      = 5'd0;
  assign bus.busy           = (state_q != IDLE);
  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = (state_q == DONE);

endmodule

// File: tb/tb_mult_sequencer.sv
// tb_mult_sequencer
//   Drives the Booth multiply sequencer with directed and random multiplies,
//   emulates the shared combinational ALU, and checks every output every cycle
//   against a model that works purely from edge numbers and a 64-bit product.
module tb_mult_sequencer;

  logic clock = 1'b0;
  logic reset;

  mult_sequencer_if bus ();

  mult_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // The shared ALU: add or subtract with a signed-overflow flag.
  logic [31:0] aluSum;
  assign aluSum = (bus.alu_opcode == 5'd1) ? (bus.alu_opA - bus.alu_opB)
                                           : (bus.alu_opA + bus.alu_opB);
  assign bus.alu_result   = aluSum;
  assign bus.alu_overflow = (bus.alu_opcode == 5'd1)
      ? ((bus.alu_opA[31] != bus.alu_opB[31]) && (aluSum[31] != bus.alu_opA[31]))
      : ((bus.alu_opA[31] == bus.alu_opB[31]) && (aluSum[31] != bus.alu_opA[31]));

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Exact signed product: {exception, low 32 bits}.
  function automatic logic [32:0] prodOf(input logic [31:0] a, input logic [31:0] b);
    longint      p;
    logic [31:0] lo;
    p  = longint'($signed(a)) * longint'($signed(b));
    lo = p[31:0];
    return {(p != longint'($signed(lo))), lo};
  endfunction

  // Reference model: a start accepted at edge S makes edges S..S+31 the ALU
  // cycles, edge S+32 delivers the result (ready visible after it) and edge
  // S+33 returns to idle, ignoring any start on that edge.
  int          edgeIdx   = 0;
  bit          inFlight  = 1'b0;
  int          startEdge = 0;
  logic [31:0] expM      = 32'd0;
  logic [31:0] expB      = 32'd0;
  logic [32:0] pend      = 33'd0;
  logic [31:0] expResult = 32'd0;
  logic        expExc    = 1'b0;

  always @(posedge clock) begin
    edgeIdx++;
    if (reset) begin
      inFlight  = 1'b0;
      expResult = 32'd0;
      expExc    = 1'b0;
    end else begin
      if (inFlight && edgeIdx == startEdge + 32) begin
        expResult = pend[31:0];
        expExc    = pend[32];
      end
      if (inFlight && edgeIdx == startEdge + 33) begin
        inFlight = 1'b0;
      end else if (!inFlight && bus.ctrl_MULT) begin
        inFlight  = 1'b1;
        startEdge = edgeIdx;
        expM      = bus.data_operandA;
        expB      = bus.data_operandB;
        pend      = prodOf(bus.data_operandA, bus.data_operandB);
      end
    end
  end

  // Every-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clock) begin
    if (edgeIdx > 0) begin
      automatic bit inRun = inFlight && (edgeIdx <= startEdge + 31);
      automatic int k     = edgeIdx - startEdge;
      automatic bit prevB;
      checkOutput("alu_req", 32'(bus.alu_req), 32'(inRun));
      checkOutput("busy", 32'(bus.busy), 32'(inFlight && (edgeIdx <= startEdge + 32)));
      checkOutput("rdy", 32'(bus.data_resultRDY), 32'(inFlight && (edgeIdx == startEdge + 32)));
      checkOutput("result", bus.data_result, expResult);
      checkOutput("exception", 32'(bus.data_exception), 32'(expExc));
      checkOutput("alu_shamt", 32'(bus.alu_shamt), 32'd0);
      if (inRun) begin
        prevB = (k > 0) ? expB[k-1] : 1'b0;
        checkOutput("alu_opB", bus.alu_opB, expM);
        checkOutput("alu_opcode", 32'(bus.alu_opcode), (expB[k] && !prevB) ? 32'd1 : 32'd0);
      end
    end
  end

  // One-cycle start pulse, driven between edges.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    bus.ctrl_MULT     = 1'b1;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(negedge clock);
    bus.ctrl_MULT     = 1'b0;
  endtask

  // Waits (bounded) for ready; optionally fires an ignored start at strayAt.
  task automatic waitRdy(input int strayAt, output bit seen, output int lat);
    seen = 1'b0;
    lat  = 0;
    for (int i = 0; i < 45; i++) begin
      if (i == strayAt) begin
        bus.ctrl_MULT     = 1'b1;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
      end else begin
        bus.ctrl_MULT = 1'b0;
      end
      @(negedge clock);
      if (bus.data_resultRDY) begin
        seen = 1'b1;
        lat  = i + 1;
        break;
      end
    end
    bus.ctrl_MULT = 1'b0;
  endtask

  task automatic runMult(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expRes, input logic expE, input int strayAt);
    bit seen;
    int lat;
    applyStimulus(a, b);
    waitRdy(strayAt, seen, lat);
    checkOutput({name, "_rdySeen"}, 32'(seen), 32'd1);
    if (seen) begin
      checkOutput({name, "_result"}, bus.data_result, expRes);
      checkOutput({name, "_exception"}, 32'(bus.data_exception), 32'(expE));
      checkOutput({name, "_latency"}, 32'(lat), 32'd32);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rdyCount;
    bit seen;
    int lat;
    logic [31:0] ra, rb;
    logic [32:0] rp;
    logic [31:0] specials [6];
    specials = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000,
                 32'h7FFF_FFFF, 32'h0000_0001, 32'h0001_0000};

    reset             = 1'b1;
    bus.ctrl_MULT     = 1'b0;
    bus.data_operandA = 32'd0;
    bus.data_operandB = 32'd0;
    repeat (2) @(negedge clock);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_req", 32'(bus.alu_req), 32'd0);
    checkOutput("reset_rdy", 32'(bus.data_resultRDY), 32'd0);
    checkOutput("reset_result", bus.data_result, 32'd0);
    checkOutput("reset_exc", 32'(bus.data_exception), 32'd0);
    reset = 1'b0;

    // Directed products with hand-computed expectations.
    runMult("basic", 32'd3, 32'd5, 32'd15, 1'b0, -1);
    runMult("negpos", 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFD6, 1'b0, -1);
    runMult("negneg", 32'hFFFF_FFF9, 32'hFFFF_FFFA, 32'd42, 1'b0, -1);
    runMult("minXm1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, -1);
    runMult("minX1", 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0, -1);
    runMult("ovf64k", 32'd65536, 32'd65536, 32'd0, 1'b1, -1);
    runMult("ovf46341", 32'd46341, 32'd46341, 32'h8000_1219, 1'b1, -1);

    // Start pulse at cycle 10 of a running multiply is ignored.
    runMult("busyIgnore", 32'd3, 32'd5, 32'd15, 1'b0, 8);
    // Start in the first idle cycle after DONE.
    runMult("backToBack", 32'd2, 32'd2, 32'd4, 1'b0, -1);

    // Reset mid-operation aborts and clears the held result.
    applyStimulus(32'd3, 32'd5);
    repeat (8) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort_req", 32'(bus.alu_req), 32'd0);
    checkOutput("abort_result", bus.data_result, 32'd0);
    reset = 1'b0;
    rdyCount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus.data_resultRDY) rdyCount++;
    end
    checkOutput("abort_noRdy", 32'(rdyCount), 32'd0);

    // Random multiplies, some with special operands and stray starts.
    for (int n = 0; n < 30; n++) begin
      ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 2) == 0) rb = rb >>> $urandom_range(0, 31);
      rp = prodOf(ra, rb);
      repeat ($urandom_range(0, 3)) @(negedge clock);
      runMult("random", ra, rb, rp[31:0], rp[32],
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 33)) : -1);
    end

    // Trailing window: the bench ALU and model stay in step while idle.
    waitRdy(-1, seen, lat);
    checkOutput("idle_noRdy", 32'(seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
